// File: rtl/sig_pattern_pkg.sv
// sig_pattern_pkg: defaults shared by the pattern generator and checker
// so both ends agree, plus the run descriptor carried by the checker FIFO.
package sig_pattern_pkg;

    localparam int          MS_CYCLES_DEF  = 27000;
    localparam int          FRAME_BITS_DEF = 15;
    localparam logic [14:0] PATTERN_DEF    = 15'b101011000111110;
    localparam int          MAX_RUN_MS_DEF = 8;
    localparam int          LEN_W_DEF      = 4;
    localparam int          FIFO_DEPTH_DEF = 4;

    typedef struct packed {
        logic                 level;
        logic [LEN_W_DEF-1:0] len;
    } run_desc_t;

endpackage

// File: rtl/sig_pattern_checker_run_fifo.sv
// run_fifo: synchronous show-ahead FIFO, head visible on data_o while
// not empty; push into a full FIFO is accepted only with a same-cycle pop.
module run_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW])
                  && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sig_pattern_checker.sv
// sig_pattern_checker: measures runs on the generator's serial line,
// streams {level, ms} descriptors and flags frame matches and errors.
module sig_pattern_checker
    import sig_pattern_pkg::*;
#(
    parameter int                    MS_CYCLES  = MS_CYCLES_DEF,
    parameter int                    FRAME_BITS = FRAME_BITS_DEF,
    parameter logic [FRAME_BITS-1:0] PATTERN    = PATTERN_DEF,
    parameter int                    MAX_RUN_MS = MAX_RUN_MS_DEF,
    parameter int                    LEN_W      = LEN_W_DEF,
    parameter int                    FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    output logic             run_valid,
    input  logic             run_ready,
    output logic             run_level,
    output logic [LEN_W-1:0] run_len,
    output logic             frame_match,
    output logic [15:0]      frame_cnt,
    output logic             err_glitch,
    output logic             err_ovf,
    output logic             line_timeout
);

    localparam int SW  = $clog2(MS_CYCLES);
    localparam int MSW = $clog2(MAX_RUN_MS + 2);
    localparam int UW  = $clog2(MAX_RUN_MS + 3);
    localparam int DW  = LEN_W + 1;

    logic                  s1_q;
    logic                  s_q;
    logic                  d_q;
    logic [SW-1:0]         sub_q, sub_d;
    logic [MSW-1:0]        ms_q, ms_d;
    logic [FRAME_BITS-1:0] hist_q, hist_d;
    logic                  upd_q, upd_d;
    logic                  match_q, match_d;
    logic [15:0]           frame_cnt_q;
    logic                  glitch_q, glitch_d;
    logic                  ovf_q, ovf_d;

    logic                  edge_w;
    logic [UW-1:0]         units;
    logic                  in_range;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [DW-1:0]         wdata;
    logic [DW-1:0]         rdata;
    logic [FRAME_BITS-1:0] ones;

    assign edge_w   = s_q ^ d_q;
    // round half up: a half-ms remainder counts as one more unit
    assign units    = UW'(ms_q)
                    + UW'(sub_q >= SW'(MS_CYCLES / 2));
    assign in_range = (units != '0)
                   && (units <= UW'(MAX_RUN_MS));
    assign push     = edge_w && in_range;
    assign pop      = run_valid && run_ready;
    assign wdata    = {d_q, LEN_W'(units)};
    assign ones     = ~({FRAME_BITS{1'b1}} << units);

    always_comb begin
        sub_d    = sub_q;
        ms_d     = ms_q;
        hist_d   = hist_q;
        upd_d    = 1'b0;
        glitch_d = 1'b0;
        if (edge_w) begin
            // the edge cycle is cycle 0 of the new run
            sub_d    = SW'(1);
            ms_d     = '0;
            glitch_d = (units == '0);
            if (in_range) begin
                hist_d = (hist_q << units)
                       | (d_q ? ones : '0);
                upd_d  = 1'b1;
            end else if (units != '0) begin
                hist_d = '0;
            end
        end else if (sub_q == SW'(MS_CYCLES - 1)) begin
            sub_d = '0;
            if (ms_q <= MSW'(MAX_RUN_MS)) begin
                ms_d = ms_q + 1'b1;
            end
        end else begin
            sub_d = sub_q + 1'b1;
        end
        match_d = upd_q && (hist_q == PATTERN);
        ovf_d   = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= 1'b0;
            s_q         <= 1'b0;
            d_q         <= 1'b0;
            sub_q       <= '0;
            ms_q        <= '0;
            hist_q      <= '0;
            upd_q       <= 1'b0;
            match_q     <= 1'b0;
            frame_cnt_q <= '0;
            glitch_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_q     <= sig;
            s_q      <= s1_q;
            d_q      <= s_q;
            sub_q    <= sub_d;
            ms_q     <= ms_d;
            hist_q   <= hist_d;
            upd_q    <= upd_d;
            match_q  <= match_d;
            glitch_q <= glitch_d;
            ovf_q    <= ovf_d;
            if (match_d) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    run_fifo #(
        .WIDTH(DW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .pop_i  (pop),
        .data_i (wdata),
        .data_o (rdata),
        .full_o (full),
        .empty_o(empty)
    );

    assign run_valid    = !empty;
    assign run_level    = run_valid & rdata[DW-1];
    assign run_len      = run_valid ? rdata[LEN_W-1:0] : '0;
    assign frame_match  = match_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_glitch   = glitch_q;
    assign err_ovf      = ovf_q;
    assign line_timeout = (ms_q > MSW'(MAX_RUN_MS));

endmodule

// File: tb/tb_sig_pattern_checker.sv
// tb_sig_pattern_checker: directed bench for sig_pattern_checker
// with MS_CYCLES=10 and the default frame, run length and FIFO depth.
module tb_sig_pattern_checker;
    import sig_pattern_pkg::*;

    localparam int MS = 10;
    localparam int FR_LV [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    localparam int FR_MS [8] = '{1, 1, 1, 1, 2, 3, 5, 1};

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sig;
    logic                 run_ready;
    logic                 run_valid;
    logic                 run_level;
    logic [LEN_W_DEF-1:0] run_len;
    logic                 frame_match;
    logic [15:0]          frame_cnt;
    logic                 err_glitch;
    logic                 err_ovf;
    logic                 line_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fm_n = 0;
    int fm_cyc = 0;
    int gl_n = 0;
    int ovf_n = 0;
    int last_rise = 0;
    run_desc_t got_q [$];
    run_desc_t exp_q [$];

    sig_pattern_checker #(
        .MS_CYCLES(MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sig         (sig),
        .run_valid   (run_valid),
        .run_ready   (run_ready),
        .run_level   (run_level),
        .run_len     (run_len),
        .frame_match (frame_match),
        .frame_cnt   (frame_cnt),
        .err_glitch  (err_glitch),
        .err_ovf     (err_ovf),
        .line_timeout(line_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (run_valid && run_ready) begin
                got_q.push_back({run_level, run_len});
            end
            if (frame_match) begin
                fm_n++;
                fm_cyc = cyc;
            end
            if (err_glitch) gl_n++;
            if (err_ovf) ovf_n++;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_runs(input string tag);
        chk({tag, "_n"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF,
                32'(exp_q[i]));
        end
    endtask

    function automatic run_desc_t rd(input int lv, input int n);
        return {lv[0], LEN_W_DEF'(n)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int lv, input int n);
        sig = lv[0];
        tick(n);
    endtask

    task automatic send_frame();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) last_rise = cyc + 1;
            drive(FR_LV[i], FR_MS[i] * MS);
        end
    endtask

    int g0;
    int o0;
    int f0;
    int n0;

    initial begin
        rst = 1'b1;
        sig = 1'b0;
        run_ready = 1'b1;
        tick(3);
        rst = 1'b0;

        // reset state
        chk("rst_valid", 32'(run_valid), 0);
        chk("rst_level", 32'(run_level), 0);
        chk("rst_len", 32'(run_len), 0);
        chk("rst_match", 32'(frame_match), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        chk("rst_glitch", 32'(err_glitch), 0);
        chk("rst_ovf", 32'(err_ovf), 0);
        chk("rst_tmo", 32'(line_timeout), 0);

        // nominal: two back-to-back frames
        drive(0, 100);
        got_q.delete();
        send_frame();
        send_frame();
        chk("nom_lat", 32'(fm_cyc - last_rise), 3);
        drive(1, 30);
        exp_q.delete();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++)
                exp_q.push_back(rd(FR_LV[i], FR_MS[i]));
        chk_runs("nom_runs");
        chk("nom_fm", 32'(fm_n), 2);
        chk("nom_cnt", 32'(frame_cnt), 2);
        chk("nom_glitch", 32'(gl_n), 0);

        // rounding: 14 -> 1, 15 -> 2, 4 -> glitch
        drive(0, 100);
        got_q.delete();
        g0 = gl_n;
        drive(1, 14);
        drive(0, 10);
        drive(1, 15);
        drive(0, 10);
        drive(1, 4);
        drive(0, 10);
        drive(1, 20);
        exp_q.delete();
        exp_q.push_back(rd(1, 1));
        exp_q.push_back(rd(0, 1));
        exp_q.push_back(rd(1, 2));
        exp_q.push_back(rd(0, 1));
        exp_q.push_back(rd(0, 1));
        chk_runs("rnd_runs");
        chk("rnd_glitch", 32'(gl_n - g0), 1);
        chk("rnd_hist", 32'(dut.hist_q), 32'h2C);

        // backpressure: six closes into a 4-deep FIFO
        run_ready = 1'b0;
        got_q.delete();
        o0 = ovf_n;
        drive(0, 10);
        drive(1, 10);
        chk("bp_head_lv0", 32'(run_level), 1);
        chk("bp_head_ln0", 32'(run_len), 2);
        drive(0, 30);
        drive(1, 10);
        drive(0, 10);
        drive(1, 10);
        tick(5);
        chk("bp_valid", 32'(run_valid), 1);
        chk("bp_head_lv", 32'(run_level), 1);
        chk("bp_head_ln", 32'(run_len), 2);
        chk("bp_ovf", 32'(ovf_n - o0), 2);
        chk("bp_nopop", 32'(got_q.size()), 0);
        run_ready = 1'b1;
        tick(8);
        exp_q.delete();
        exp_q.push_back(rd(1, 2));
        exp_q.push_back(rd(0, 1));
        exp_q.push_back(rd(1, 1));
        exp_q.push_back(rd(0, 3));
        chk_runs("bp_drain");
        chk("bp_empty", 32'(run_valid), 0);

        // timeout on a 100-cycle low
        drive(0, 50);
        chk("tmo_early", 32'(line_timeout), 0);
        n0 = got_q.size();
        f0 = fm_n;
        drive(0, 50);
        chk("tmo_high", 32'(line_timeout), 1);
        drive(1, 5);
        chk("tmo_clear", 32'(line_timeout), 0);
        chk("tmo_nopush", 32'(got_q.size()), 32'(n0));
        chk("tmo_hist", 32'(dut.hist_q), 0);
        chk("tmo_nofm", 32'(fm_n), 32'(f0));

        // reset halfway through a frame
        drive(0, 100);
        run_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            drive(FR_LV[i], FR_MS[i] * MS);
        sig = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mrst_valid", 32'(run_valid), 0);
        chk("mrst_level", 32'(run_level), 0);
        chk("mrst_len", 32'(run_len), 0);
        chk("mrst_match", 32'(frame_match), 0);
        chk("mrst_cnt", 32'(frame_cnt), 0);
        chk("mrst_tmo", 32'(line_timeout), 0);
        run_ready = 1'b1;
        f0 = fm_n;
        drive(0, 100);
        send_frame();
        drive(1, 10);
        chk("mrst_fm", 32'(fm_n - f0), 1);
        chk("mrst_cnt1", 32'(frame_cnt), 1);

        // frame_cnt wraps 0xFFFF -> 0
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        f0 = fm_n;
        drive(0, 100);
        send_frame();
        drive(1, 10);
        chk("wrap_fm", 32'(fm_n - f0), 1);
        chk("wrap_cnt", 32'(frame_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
